// File: rtl/ifmap_row_loader_if.sv
// Valid/ready IF-map word stream into the row loader; in_last marks the final word of a row.
interface ifmap_row_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;

  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave  (input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/ifmap_row_loader.sv
// Writes IF-map rows into the circular scratchpad and emits start/end table loads per row.
// Optional feature: define IFMAP_LOADER_OVF_CHECK_EN to flag and discard rows larger than the scratchpad.
module ifmap_row_loader #(
  parameter int IF_MAP_HEIGHT = 8,
  parameter int MAX_ROW       = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int ADD_WIDTH     = (IF_MAP_HEIGHT > 1) ? $clog2(IF_MAP_HEIGHT) : 1,
  parameter int ROW_PTR_WIDTH = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  ifmap_row_loader_if.slave        in_if,
  output logic                     spad_wen,
  output logic [ADD_WIDTH-1:0]     spad_waddr,
  output logic [DATA_WIDTH-1:0]    spad_wdata,
  output logic                     ld_start,
  output logic                     ld_end,
  output logic [ADD_WIDTH-1:0]     start_out,
  output logic [ADD_WIDTH-1:0]     end_out,
  output logic [ROW_PTR_WIDTH-1:0] row_slot,
  input  logic                     row_release,
  output logic [ROW_PTR_WIDTH:0]   rows_valid,
  output logic                     full,
  output logic                     busy,
  output logic                     err
);
  localparam int LEN_W = ADD_WIDTH + 1;
  localparam int RV_W  = ROW_PTR_WIDTH + 1;
  localparam logic [LEN_W-1:0]         DEPTH     = LEN_W'(IF_MAP_HEIGHT);
  localparam logic [ADD_WIDTH-1:0]     LAST_ADDR = ADD_WIDTH'(IF_MAP_HEIGHT - 1);
  localparam logic [ROW_PTR_WIDTH-1:0] LAST_SLOT = ROW_PTR_WIDTH'(MAX_ROW - 1);
  localparam logic [RV_W-1:0]          ROWS_MAX  = RV_W'(MAX_ROW);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DROP} state_t;

  state_t                   state;
  logic [ADD_WIDTH-1:0]     wptr;
  logic [ADD_WIDTH-1:0]     row_start;
  logic [ROW_PTR_WIDTH-1:0] rd_slot;
  logic [LEN_W-1:0]         words_used;
  logic [LEN_W-1:0]         cur_len;
  logic [LEN_W-1:0]         len_tab [MAX_ROW];

  logic             accept;
  logic             wr;
  logic             commit;
  logic             rel;
  logic             ovf;
  logic             drop_done;
  logic [LEN_W-1:0] rel_len;
  logic [LEN_W-1:0] drop_len;
  logic [LEN_W-1:0] words_used_nxt;

  function automatic logic [ADD_WIDTH-1:0] next_addr(input logic [ADD_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [ROW_PTR_WIDTH-1:0] next_slot(input logic [ROW_PTR_WIDTH-1:0] s);
    return (s == LAST_SLOT) ? '0 : s + 1'b1;
  endfunction

  // NOTE: every path must assign in_ready, so it is defaulted first; a missing default infers a latch.
  always_comb begin
    in_if.in_ready = 1'b0;
    case (state)
      LOAD:    in_if.in_ready = (words_used < DEPTH);
      DROP:    in_if.in_ready = 1'b1;
      default: in_if.in_ready = 1'b0;
    endcase
  end

  assign accept  = in_if.in_valid && in_if.in_ready;
  assign wr      = accept && (state == LOAD);
  assign commit  = (state == COMMIT);
  // The row being loaded is not counted in rows_valid, so it can never be released early.
  assign rel     = row_release && (rows_valid != '0);
  assign rel_len = rel ? len_tab[rd_slot] : '0;

`ifdef IFMAP_LOADER_OVF_CHECK_EN
  assign ovf       = (state == LOAD) && (rows_valid == '0) && (cur_len == DEPTH);
  assign drop_done = accept && in_if.in_last && (state == DROP);
`else
  assign ovf       = 1'b0;
  assign drop_done = 1'b0;
`endif

  // A dropped row gives back every word it had written before the overflow.
  assign drop_len       = drop_done ? cur_len : '0;
  assign words_used_nxt = words_used + LEN_W'(wr) - rel_len - drop_len;

  assign spad_wen   = wr;
  assign spad_waddr = wptr;
  assign spad_wdata = in_if.in_data;
  assign ld_start   = (state == IDLE) && en && !full;
  assign ld_end     = commit;
  assign start_out  = wptr;
  assign end_out    = wptr;
  assign full       = (rows_valid == ROWS_MAX);
  assign busy       = (state != IDLE);

`ifdef IFMAP_LOADER_OVF_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // NOTE: state is updated only with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wptr       <= '0;
      row_start  <= '0;
      row_slot   <= '0;
      rd_slot    <= '0;
      rows_valid <= '0;
      words_used <= '0;
      cur_len    <= '0;
`ifdef IFMAP_LOADER_OVF_CHECK_EN
      err_q      <= 1'b0;
`endif
      // NOTE: the length table is tiny and feeds words_used arithmetic, so it is reset explicitly.
      for (int i = 0; i < MAX_ROW; i++) len_tab[i] <= '0;
    end else begin
      words_used <= words_used_nxt;
      if (rel) rd_slot <= next_slot(rd_slot);
      if (commit && !rel)      rows_valid <= rows_valid + 1'b1;
      else if (rel && !commit) rows_valid <= rows_valid - 1'b1;
      if (wr) wptr <= next_addr(wptr);

      case (state)
        IDLE: begin
          if (ld_start) begin
            state     <= LOAD;
            row_start <= wptr;
          end
        end
        LOAD: begin
          if (ovf) begin
            state <= DROP;
`ifdef IFMAP_LOADER_OVF_CHECK_EN
            err_q <= 1'b1;
`endif
          end else if (wr) begin
            cur_len <= cur_len + 1'b1;
            if (in_if.in_last) state <= COMMIT;
          end
        end
        COMMIT: begin
          len_tab[row_slot] <= cur_len;
          cur_len           <= '0;
          row_slot          <= next_slot(row_slot);
          state             <= IDLE;
        end
        DROP: begin
          if (drop_done) begin
            wptr    <= row_start;
            cur_len <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifmap_row_loader.sv
// Self-checking bench for ifmap_row_loader with IF_MAP_HEIGHT=8, MAX_ROW=2.
module tb_ifmap_row_loader;
  localparam int H  = 8;
  localparam int R  = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          row_release;
  logic          spad_wen, ld_start, ld_end, full, busy, err;
  logic [2:0]    spad_waddr, start_out, end_out;
  logic [DW-1:0] spad_wdata;
  logic [0:0]    row_slot;
  logic [1:0]    rows_valid;

  ifmap_row_loader_if #(.DATA_WIDTH(DW)) bus ();

  ifmap_row_loader #(.IF_MAP_HEIGHT(H), .MAX_ROW(R), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_if(bus),
    .spad_wen(spad_wen), .spad_waddr(spad_waddr), .spad_wdata(spad_wdata),
    .ld_start(ld_start), .ld_end(ld_end), .start_out(start_out), .end_out(end_out),
    .row_slot(row_slot), .row_release(row_release), .rows_valid(rows_valid),
    .full(full), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] addr; logic [DW-1:0] data; } wr_exp_t;
  typedef struct packed { logic [2:0] addr; logic slot; } tbl_exp_t;
  typedef enum int {OP_ROW, OP_EN, OP_REL} op_t;
  typedef struct { op_t op; int n; logic [1:0] rows; logic full; } vec_t;

  wr_exp_t  wr_q[$];
  tbl_exp_t start_q[$];
  tbl_exp_t end_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int m_wptr   = 0;
  int m_slot   = 0;
  logic [DW-1:0] m_data = 16'h1000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Scoreboard: pops expected writes / table loads whenever the DUT strobes them.
  always begin
    wr_exp_t  w;
    tbl_exp_t t;
    @(negedge clk);
    #2;
    if (spad_wen === 1'b1) begin
      if (wr_q.size() == 0) check("spurious_wen", 32'(spad_wen), 32'd0);
      else begin
        w = wr_q.pop_front();
        check("waddr", 32'(spad_waddr), 32'(w.addr));
        check("wdata", 32'(spad_wdata), 32'(w.data));
      end
    end
    if (ld_start === 1'b1) begin
      if (start_q.size() == 0) check("spurious_ld_start", 32'(ld_start), 32'd0);
      else begin
        t = start_q.pop_front();
        check("start_out", 32'(start_out), 32'(t.addr));
        check("start_slot", 32'(row_slot), 32'(t.slot));
      end
    end
    if (ld_end === 1'b1) begin
      if (end_q.size() == 0) check("spurious_ld_end", 32'(ld_end), 32'd0);
      else begin
        t = end_q.pop_front();
        check("end_out", 32'(end_out), 32'(t.addr));
        check("end_slot", 32'(row_slot), 32'(t.slot));
      end
    end
  end

  task automatic begin_row(input int n, input logic with_end);
    tbl_exp_t s, e;
    s.addr = 3'(m_wptr);
    s.slot = 1'(m_slot);
    start_q.push_back(s);
    if (with_end) begin
      e.addr = 3'((m_wptr + n) % H);
      e.slot = 1'(m_slot);
      end_q.push_back(e);
    end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic send_word(input logic last, input logic expect_write);
    int      waited;
    wr_exp_t e;
    waited = 0;
    m_data = m_data + 16'h0111;
    bus.in_data  = m_data;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    if (expect_write) begin
      e.addr = 3'(m_wptr);
      e.data = m_data;
      wr_q.push_back(e);
      m_wptr = (m_wptr + 1) % H;
    end
    #1;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_row(input int n);
    begin_row(n, 1'b1);
    for (int i = 0; i < n; i++) send_word(i == n - 1, 1'b1);
    @(negedge clk);
    m_slot = (m_slot + 1) % R;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    en           = 1'b0;
    row_release  = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rows_valid", 32'(rows_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    m_wptr = 0;
    m_slot = 0;
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    case (v.op)
      OP_ROW: send_row(v.n);
      OP_EN: begin
        en = 1'b1;
        #1 check($sformatf("v%0d_ld_start", i), 32'(ld_start), 32'd0);
        @(negedge clk);
        en = 1'b0;
      end
      default: begin
        row_release = 1'b1;
        @(negedge clk);
        row_release = 1'b0;
      end
    endcase
    #1;
    check($sformatf("v%0d_rows_valid", i), 32'(rows_valid), 32'(v.rows));
    check($sformatf("v%0d_full", i), 32'(full), 32'(v.full));
    check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
    check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{op: OP_ROW, n: 5, rows: 2'd1, full: 1'b0};
    vecs[1] = '{op: OP_ROW, n: 2, rows: 2'd2, full: 1'b1};
    vecs[2] = '{op: OP_EN,  n: 0, rows: 2'd2, full: 1'b1};
    vecs[3] = '{op: OP_REL, n: 0, rows: 2'd1, full: 1'b0};
    vecs[4] = '{op: OP_REL, n: 0, rows: 2'd0, full: 1'b0};
    vecs[5] = '{op: OP_REL, n: 0, rows: 2'd0, full: 1'b0};
    vecs[6] = '{op: OP_ROW, n: 3, rows: 2'd1, full: 1'b0};
    vecs[7] = '{op: OP_REL, n: 0, rows: 2'd0, full: 1'b0};

    rst = 1'b0; en = 1'b0; row_release = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_ld_end", 32'(ld_end), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Partial row of three words cut short by reset: no ld_end, state back to empty.
    begin_row(3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(1'b0, 1'b1);
    check("midrow_busy", 32'(busy), 32'd1);
    apply_reset();
    @(negedge clk);

    apply_vec(0, vecs[0]);

    // Second row wraps the scratchpad, stalls on a full buffer, resumes after a release.
    begin_row(5, 1'b1);
    for (int i = 0; i < 3; i++) send_word(1'b0, 1'b1);
    begin
      wr_exp_t e;
      m_data = m_data + 16'h0111;
      bus.in_data = m_data; bus.in_valid = 1'b1; bus.in_last = 1'b0;
      e.addr = 3'(m_wptr); e.data = m_data;
      wr_q.push_back(e);
      m_wptr = (m_wptr + 1) % H;
    end
    #1 check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #1 check("stall_in_ready_hold", 32'(bus.in_ready), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    @(negedge clk);
    row_release = 1'b1;
    @(negedge clk);
    row_release = 1'b0;
    #1 check("ready_after_release", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    send_word(1'b1, 1'b1);
    @(negedge clk);
    m_slot = (m_slot + 1) % R;
    #1;
    check("slot_wrap", 32'(row_slot), 32'd0);
    check("row2_rows_valid", 32'(rows_valid), 32'd1);
    @(negedge clk);

    for (int i = 1; i <= 3; i++) apply_vec(i, vecs[i]);

    // Release in the same cycle as a commit leaves rows_valid unchanged.
    begin_row(1, 1'b1);
    send_word(1'b1, 1'b1);
    row_release = 1'b1;
    #1 check("commit_rel_ld_end", 32'(ld_end), 32'd1);
    @(negedge clk);
    row_release = 1'b0;
    m_slot = (m_slot + 1) % R;
    #1;
    check("commit_rel_rows_valid", 32'(rows_valid), 32'd1);
    check("commit_rel_full", 32'(full), 32'd0);
    @(negedge clk);

    for (int i = 4; i <= 7; i++) apply_vec(i, vecs[i]);

`ifdef IFMAP_LOADER_OVF_CHECK_EN
    // Ten-word row into an empty buffer: eight written, then flagged and drained.
    begin
      int row_start_m;
      row_start_m = m_wptr;
      begin_row(10, 1'b0);
      for (int i = 0; i < 8; i++) send_word(1'b0, 1'b1);
      send_word(1'b0, 1'b0);
      check("ovf_err_set", 32'(err), 32'd1);
      check("ovf_busy_drop", 32'(busy), 32'd1);
      send_word(1'b1, 1'b0);
      #1;
      check("ovf_idle", 32'(busy), 32'd0);
      check("ovf_rows_valid", 32'(rows_valid), 32'd0);
      m_wptr = row_start_m;
      @(negedge clk);
    end
`else
    // Oversize row without overflow checking stalls in LOAD until reset.
    begin_row(10, 1'b0);
    for (int i = 0; i < 8; i++) send_word(1'b0, 1'b1);
    m_data = m_data + 16'h0111;
    bus.in_data = m_data; bus.in_valid = 1'b1; bus.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("oversize_stall_%0d", i), 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    check("oversize_err", 32'(err), 32'd0);
    check("oversize_busy", 32'(busy), 32'd1);
    apply_reset();
    @(negedge clk);
`endif

    send_row(1);
    #1 check("final_rows_valid", 32'(rows_valid), 32'd1);
`ifdef IFMAP_LOADER_OVF_CHECK_EN
    check("err_sticky", 32'(err), 32'd1);
`else
    check("err_tied", 32'(err), 32'd0);
`endif
    @(negedge clk);
    row_release = 1'b1;
    @(negedge clk);
    row_release = 1'b0;
    #1 check("final_release", 32'(rows_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);

    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("start_q_drained", 32'(start_q.size()), 32'd0);
    check("end_q_drained", 32'(end_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
